// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: sequences load-use stalls, taken-branch redirects and
// instruction-memory backpressure, and keeps a saturating count of accepted redirects.
module pc_redirect_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic             is_ctrl,
  input  logic             leap,
  input  logic             load_hazard,
  input  logic [0:31]      target,
  input  logic             imem_ready,
  input  logic             count_clr,
  output logic             pc_sel,
  output logic [0:31]      redirect_pc,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             misalign,
  output logic [0:CNT_W-1] taken_count
);

  typedef enum logic [1:0] {RUN, HAZARD, REDIRECT} state_t;

  state_t           state_q, state_d;
  logic [0:31]      rpc_q, rpc_d;
  logic             mis_q, mis_d;
  logic [0:CNT_W-1] cnt_q, cnt_d;

  logic ctrl;
  logic accept;
  logic pc_sel_c, stall_if_c, stall_id_c, flush_id_c;

  assign ctrl = id_valid & is_ctrl;

  always_comb begin
    state_d    = RUN;
    rpc_d      = rpc_q;
    mis_d      = mis_q;
    accept     = 1'b0;
    pc_sel_c   = 1'b0;
    stall_if_c = 1'b0;
    stall_id_c = 1'b0;
    flush_id_c = 1'b0;
    case (state_q)
      RUN, HAZARD: begin
        // In HAZARD the operand is forwarded, so load_hazard no longer applies.
        if (ctrl && load_hazard && (state_q == RUN)) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          state_d    = HAZARD;
        end else if (ctrl && leap) begin
          flush_id_c = 1'b1;
          rpc_d      = target;
          accept     = 1'b1;
          state_d    = REDIRECT;
          if (target[30:31] != 2'b00) mis_d = 1'b1;
        end
      end
      REDIRECT: begin
        pc_sel_c   = 1'b1;
        flush_id_c = 1'b1;
        if (imem_ready) begin
          state_d = RUN;
        end else begin
          stall_if_c = 1'b1;
          state_d    = REDIRECT;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (accept && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      rpc_q   <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gate combinational controls so reset silences them without waiting for an edge.
  assign pc_sel      = pc_sel_c   & reset_n;
  assign stall_if    = stall_if_c & reset_n;
  assign stall_id    = stall_id_c & reset_n;
  assign flush_id    = flush_id_c & reset_n;
  assign redirect_pc = rpc_q;
  assign misalign    = mis_q;
  assign taken_count = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: a reference model pushes expected
// outputs to a scoreboard queue as stimulus is driven; they are popped and compared mid-cycle.
module tb_pc_redirect_ctrl;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             id_valid, is_ctrl, leap, load_hazard;
  logic [31:0]      target;
  logic             imem_ready, count_clr;
  logic             pc_sel;
  logic [31:0]      redirect_pc;
  logic             stall_if, stall_id, flush_id, misalign;
  logic [CNT_W-1:0] taken_count;

  pc_redirect_ctrl #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .id_valid    (id_valid),
    .is_ctrl     (is_ctrl),
    .leap        (leap),
    .load_hazard (load_hazard),
    .target      (target),
    .imem_ready  (imem_ready),
    .count_clr   (count_clr),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .flush_id    (flush_id),
    .misalign    (misalign),
    .taken_count (taken_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pc_sel;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic [31:0] rpc;
    logic        mis;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // model state: 0 = RUN, 1 = HAZARD, 2 = REDIRECT
  int          m_state, n_state;
  logic [31:0] m_rpc, n_rpc;
  logic        m_mis, n_mis;
  logic [3:0]  m_cnt, n_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rpc = '0; m_mis = 1'b0; m_cnt = '0;
    n_state = 0; n_rpc = '0; n_mis = 1'b0; n_cnt = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".pc_sel"},   {31'd0, pc_sel},   32'd0);
    check_val({tag, ".stall_if"}, {31'd0, stall_if}, 32'd0);
    check_val({tag, ".stall_id"}, {31'd0, stall_id}, 32'd0);
    check_val({tag, ".flush_id"}, {31'd0, flush_id}, 32'd0);
    check_val({tag, ".rpc"},      redirect_pc,       32'd0);
    check_val({tag, ".mis"},      {31'd0, misalign}, 32'd0);
    check_val({tag, ".cnt"},      {28'd0, taken_count}, 32'd0);
  endtask

  // One clock cycle: commit model state at the edge, drive inputs, predict, then compare.
  task automatic step(input logic v, input logic c, input logic l, input logic h,
                      input logic [31:0] t, input logic rdy, input logic clr);
    exp_t e;
    logic ct, inc;
    @(posedge clock);
    m_state = n_state; m_rpc = n_rpc; m_mis = n_mis; m_cnt = n_cnt;
    #1;
    id_valid = v; is_ctrl = c; leap = l; load_hazard = h;
    target = t; imem_ready = rdy; count_clr = clr;

    ct = v & c;
    inc = 1'b0;
    e.pc_sel = 1'b0; e.stall_if = 1'b0; e.stall_id = 1'b0; e.flush_id = 1'b0;
    e.rpc = m_rpc; e.mis = m_mis; e.cnt = m_cnt;
    n_state = 0; n_rpc = m_rpc; n_mis = m_mis;
    if (m_state == 2) begin
      e.pc_sel = 1'b1;
      e.flush_id = 1'b1;
      e.stall_if = ~rdy;
      n_state = rdy ? 0 : 2;
    end else if (ct && h && m_state == 0) begin
      e.stall_if = 1'b1;
      e.stall_id = 1'b1;
      n_state = 1;
    end else if (ct && l) begin
      e.flush_id = 1'b1;
      n_state = 2;
      n_rpc = t;
      inc = 1'b1;
      if (t[1:0] != 2'b00) n_mis = 1'b1;
    end
    if (clr) n_cnt = 4'd0;
    else if (inc && m_cnt != 4'hF) n_cnt = m_cnt + 4'd1;
    else n_cnt = m_cnt;
    exp_q.push_back(e);

    #3;
    e = exp_q.pop_front();
    txn++;
    check_val("pc_sel",   {31'd0, pc_sel},   {31'd0, e.pc_sel});
    check_val("stall_if", {31'd0, stall_if}, {31'd0, e.stall_if});
    check_val("stall_id", {31'd0, stall_id}, {31'd0, e.stall_id});
    check_val("flush_id", {31'd0, flush_id}, {31'd0, e.flush_id});
    check_val("redirect_pc", redirect_pc,    e.rpc);
    check_val("misalign", {31'd0, misalign}, {31'd0, e.mis});
    check_val("taken_count", {28'd0, taken_count}, {28'd0, e.cnt});
    $display("txn %0d: v=%0b c=%0b l=%0b h=%0b rdy=%0b clr=%0b -> pc_sel=%0b sif=%0b sid=%0b fl=%0b rpc=%08h mis=%0b cnt=%0d",
             txn, v, c, l, h, rdy, clr, pc_sel, stall_if, stall_id, flush_id,
             redirect_pc, misalign, taken_count);
  endtask

  initial begin
    reset_n = 1'b0;
    id_valid = 0; is_ctrl = 0; leap = 0; load_hazard = 0;
    target = '0; imem_ready = 1; count_clr = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #4;
    check_reset_outputs("reset");
    @(posedge clock);
    #1 reset_n = 1'b1;

    // idle
    repeat (10) step(0, 0, 0, 0, 32'h0, 1, 0);

    // id_valid=0 suppresses everything
    step(0, 1, 1, 1, 32'h0000_1234, 1, 0);

    // taken, memory ready
    step(1, 1, 1, 0, 32'h0000_0040, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);

    // load-use branch
    step(1, 1, 1, 1, 32'h0000_0080, 1, 0);
    step(1, 1, 1, 1, 32'h0000_0080, 1, 0);
    step(1, 1, 1, 1, 32'h0000_0999, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);

    // memory backpressure
    step(1, 1, 1, 0, 32'h0000_0100, 1, 0);
    repeat (3) step(1, 1, 1, 1, 32'h0000_0200, 0, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);

    // saturation then clear with simultaneous redirect
    for (int i = 0; i < 17; i++) begin
      step(1, 1, 1, 0, 32'h1000 + 32'(i) * 4, 1, 0);
      step(0, 0, 0, 0, 32'h0, 1, 0);
    end
    step(1, 1, 1, 0, 32'h0000_2000, 1, 1);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0));
    end
    repeat (3) step(0, 0, 0, 0, 32'h0, 1, 0);

    // misaligned target, then reset while in REDIRECT
    step(1, 1, 1, 0, 32'h0000_0042, 0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;

    // first post-reset cycle behaves as RUN
    step(1, 1, 1, 0, 32'h0000_0300, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of taken_count.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port id_valid, input, 1: ID stage holds a valid instruction.
REQ-005 SHALL have port is_ctrl, input, 1: ID instruction is a branch or jump.
REQ-006 SHALL have port leap, input, 1: branch/jump taken, from branch check.
REQ-007 SHALL have port load_hazard, input, 1: branch source register is the destination of a load in EX.
REQ-008 SHALL have port target, input, [0:31]: taken destination address.
REQ-009 SHALL have port imem_ready, input, 1: instruction memory accepts a fetch address this cycle.
REQ-010 SHALL have port count_clr, input, 1: synchronous clear of taken_count.
REQ-011 SHALL have port pc_sel, output, 1: 0 = sequential PC+4, 1 = redirect_pc.
REQ-012 SHALL have port redirect_pc, output, [0:31]: registered redirect address.
REQ-013 SHALL have ports stall_if, stall_id, flush_id, outputs, 1 each: hold IF, hold ID, squash IF/ID latch at next edge.
REQ-014 SHALL have port misalign, output, 1: sticky, a taken target had target[30:31] != 0.
REQ-015 SHALL have port taken_count, output, [0:CNT_W-1]: accepted redirects, saturating.

Function
REQ-016 SHALL implement FSM states RUN, HAZARD, REDIRECT; "ctrl" = id_valid & is_ctrl.
REQ-017 In RUN, ctrl & load_hazard SHALL assert stall_if=stall_id=1 combinationally and go to HAZARD; leap ignored that cycle.
REQ-018 HAZARD SHALL last one cycle and evaluate as RUN with load_hazard treated as 0 (operand now forwarded).
REQ-019 In RUN/HAZARD, ctrl & leap (hazard not applicable) SHALL assert flush_id=1 combinationally, capture target into redirect_pc, and go to REDIRECT.
REQ-020 In RUN/HAZARD, ctrl & ~leap, or ~ctrl, SHALL keep all stall/flush outputs 0, pc_sel=0, next state RUN.
REQ-021 In REDIRECT, pc_sel SHALL be 1; with imem_ready=1 go to RUN next edge; with imem_ready=0 assert stall_if=1 and stay.
REQ-022 In REDIRECT, flush_id SHALL be 1 each cycle (wrong-path fetches squashed); leap, is_ctrl, load_hazard SHALL be ignored.
REQ-023 Redirect latency: first cycle pc_sel=1 is exactly one cycle after leap is accepted.
REQ-024 taken_count SHALL increment by 1 on each RUN/HAZARD->REDIRECT transition, saturate at all-ones, never wrap.
REQ-025 count_clr SHALL zero taken_count next edge and take priority over a simultaneous increment.
REQ-026 misalign SHALL set on a captured target with target[30:31] != 0, and clear only on reset; redirect still proceeds, address unmodified.
REQ-027 id_valid=0 SHALL suppress is_ctrl, leap and load_hazard regardless of their values.

Reset
REQ-028 reset_n=0 SHALL immediately force state RUN, pc_sel=0, stall_if=stall_id=flush_id=0, redirect_pc=0, misalign=0, taken_count=0.
REQ-029 Reset asserted in REDIRECT or HAZARD SHALL abandon the operation without a count increment; first post-reset cycle behaves as RUN.

Verification
REQ-030 Reset then idle: id_valid=0, 10 cycles -> pc_sel=0, all stalls/flush 0, taken_count=0.
REQ-031 Taken, memory ready: ctrl, leap=1, target=0x00000040, imem_ready=1 -> flush_id=1 in cycle 0; cycle 1 pc_sel=1, redirect_pc=0x40; cycle 2 RUN; taken_count=1.
REQ-032 Load-use branch: ctrl, load_hazard=1, leap=1 -> cycle 0 stall_if=stall_id=1, no flush; cycle 1 (HAZARD) leap=1 -> flush_id=1; cycle 2 pc_sel=1.
REQ-033 Memory backpressure: redirect with imem_ready=0 for 3 cycles -> pc_sel=1, stall_if=1, flush_id=1 for 3 cycles; RUN after imem_ready=1.
REQ-034 Saturation/clear: CNT_W=4, 17 taken redirects -> taken_count=0xF; count_clr with simultaneous redirect -> 0.
REQ-035 Misalign and mid-op reset: target=0x00000042 -> misalign=1; reset_n=0 during REDIRECT -> all outputs at reset values asynchronously.
